// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/miss conditions in, stage enables, flushes and refill strobes out.
interface pipeline_ctrl_if;
    logic       mem_access;
    logic       dcache_hit;
    logic       mem_ready;
    logic       branch_taken;
    logic       id_ex_memread;
    logic [2:0] id_ex_rt;
    logic [2:0] if_id_rs;
    logic [2:0] if_id_rt;
    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_hit;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       refill_req;
    logic [1:0] refill_word;
    logic       refill_we;
    logic       busy;
    logic [7:0] miss_count;

    modport master (
        input  mem_access, dcache_hit, mem_ready, branch_taken, id_ex_memread, id_ex_rt, if_id_rs, if_id_rt,
        output pc_en, if_id_en, id_ex_en, ex_mem_hit, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush,
        output refill_req, refill_word, refill_we, busy, miss_count
    );

    modport slave (
        output mem_access, dcache_hit, mem_ready, branch_taken, id_ex_memread, id_ex_rt, if_id_rs, if_id_rt,
        input  pc_en, if_id_en, id_ex_en, ex_mem_hit, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush,
        input  refill_req, refill_word, refill_we, busy, miss_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stalls the pipeline across a 4-word dcache refill and resolves branch flushes and load-use stalls.
module pipeline_ctrl (
    input logic           clk,
    input logic           rst,
    pipeline_ctrl_if.master bus
);
    localparam logic [1:0] RUN    = 2'b00;
    localparam logic [1:0] REFILL = 2'b01;
    localparam logic [1:0] RESUME = 2'b10;

    logic [1:0] state;
    logic [1:0] cnt;
    logic [7:0] misses;
    logic       miss, hazard, run, refill, done;
    logic [4:0] en;
    logic [2:0] fl;

    assign miss   = bus.mem_access & ~bus.dcache_hit;
    assign hazard = bus.id_ex_memread & (bus.id_ex_rt != 3'd0) &
                    ((bus.id_ex_rt == bus.if_id_rs) | (bus.id_ex_rt == bus.if_id_rt));
    assign run    = state == RUN;
    assign refill = state == REFILL;
    assign done   = refill & bus.mem_ready & (cnt == 2'd3);

    // Branch outranks the load-use stall: the stalled ID instruction is flushed anyway.
    assign en = (rst | ~run | miss) ? 5'b00000 :
                (hazard & ~bus.branch_taken) ? 5'b00111 : 5'b11111;
    assign fl = rst ? 3'b111 :
                (~run | miss) ? 3'b000 :
                bus.branch_taken ? 3'b111 :
                hazard ? 3'b010 : 3'b000;

    assign {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_hit, bus.mem_wb_en} = en;
    assign {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush} = fl;
    assign bus.refill_req  = refill & ~rst;
    assign bus.refill_we   = refill & ~rst & bus.mem_ready;
    assign bus.refill_word = cnt;
    assign bus.busy        = ~run;
    assign bus.miss_count  = misses;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            cnt    <= 2'd0;
            misses <= 8'd0;
        end else begin
            state  <= run ? (miss ? REFILL : RUN) : refill ? (done ? RESUME : REFILL) : RUN;
            cnt    <= run ? 2'd0 : (refill & bus.mem_ready) ? cnt + 2'd1 : cnt;
            misses <= (done & (misses != 8'hff)) ? misses + 8'd1 : misses;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random stimulus checked against a phase-based model of the controller.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail = 0;

    // Model: refilling / resuming flags, words received so far, completed refills.
    bit   refilling = 0;
    bit   resuming = 0;
    int   words = 0;
    int   completed = 0;

    pipeline_ctrl_if bus ();
    pipeline_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ma, dh, mr, br, rd, input logic [2:0] ert, rs, rt, input logic r);
        logic [4:0] e_en;
        logic [2:0] e_fl;
        logic       e_req, e_we, miss, haz;
        bus.mem_access = ma; bus.dcache_hit = dh; bus.mem_ready = mr; bus.branch_taken = br;
        bus.id_ex_memread = rd; bus.id_ex_rt = ert; bus.if_id_rs = rs; bus.if_id_rt = rt; rst = r;
        #3;
        miss = ma && !dh;
        haz  = rd && ert != 0 && (ert == rs || ert == rt);
        e_req = 0; e_we = 0; e_fl = 3'b000; e_en = 5'b00000;
        if (r) e_fl = 3'b111;
        else if (refilling) begin e_req = 1; e_we = mr; end
        else if (resuming || miss) e_en = 5'b00000;
        else if (br) begin e_en = 5'b11111; e_fl = 3'b111; end
        else if (haz) begin e_en = 5'b00111; e_fl = 3'b010; end
        else e_en = 5'b11111;
        chk("enables", {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_hit, bus.mem_wb_en}, e_en);
        chk("flushes", {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}, e_fl);
        chk("refill_req", bus.refill_req, e_req);
        chk("refill_we", bus.refill_we, e_we);
        if (e_req) chk("refill_word", bus.refill_word, words);
        chk("busy", bus.busy, refilling || resuming);
        chk("miss_count", bus.miss_count, completed);
        @(posedge clk);
        if (r) begin
            refilling = 0; resuming = 0; words = 0; completed = 0;
        end else if (resuming) resuming = 0;
        else if (refilling) begin
            if (mr) words++;
            if (words == 4) begin
                refilling = 0; resuming = 1; words = 0;
                if (completed < 255) completed++;
            end
        end else if (miss) begin
            refilling = 1; words = 0;
        end
        #1;
    endtask

    initial begin
        bus.mem_access = 0; bus.dcache_hit = 0; bus.mem_ready = 0; bus.branch_taken = 0;
        bus.id_ex_memread = 0; bus.id_ex_rt = 0; bus.if_id_rs = 0; bus.if_id_rt = 0; rst = 1;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Refill aborted by reset at word 2
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("abort_count", bus.miss_count, 0);
        // Miss with mem_ready held high
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (5) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("one_refill", bus.miss_count, 1);
        // Miss with mem_ready pulsing
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, logic'(i % 2 == 0), 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use hazard, then rt=0 which must not stall
        step(0, 0, 0, 0, 1, 3, 3, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 1, 5, 0);
        // Branch with hazard, branch with miss, conditions ignored while busy
        step(0, 0, 0, 1, 1, 3, 3, 0, 0);
        step(1, 0, 0, 1, 1, 3, 3, 0, 0);
        repeat (4) step(0, 0, 1, 1, 1, 3, 3, 0, 0);
        step(0, 0, 0, 1, 1, 3, 3, 0, 0);
        step(0, 0, 0, 1, 1, 3, 3, 0, 0);
        // Saturation after 256 refills
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (256) begin
            step(1, 0, 1, 0, 0, 0, 0, 0, 0);
            repeat (5) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        end
        chk("saturated", bus.miss_count, 255);
        // Random traffic
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3000)
            step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)),
                 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                 logic'($urandom_range(0, 99) == 0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge of clk.
REQ-002 rst  input  1  synchronous reset, active-high.
REQ-003 mem_access  input  1  MEM-stage instruction reads or writes data memory.
REQ-004 dcache_hit  input  1  data cache hit for the current MEM-stage access.
REQ-005 mem_ready  input  1  main memory presents one refill word this cycle.
REQ-006 branch_taken  input  1  MEM-stage Branch AND Zero.
REQ-007 id_ex_memread  input  1  EX-stage instruction is a load.
REQ-008 id_ex_rt  input  3  EX-stage load destination register.
REQ-009 if_id_rs, if_id_rt  input  3 each  ID-stage source registers.
REQ-010 pc_en, if_id_en, id_ex_en, ex_mem_hit, mem_wb_en  output  1 each  stage hold/advance enables; ex_mem_hit drives the EX/MEM register hit input.
REQ-011 if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  load a bubble (all controls 0) into the stage register.
REQ-012 refill_req  output  1  refill in progress, request to main memory.
REQ-013 refill_word  output  2  index of the word being written into the cache line.
REQ-014 refill_we  output  1  cache line word write strobe.
REQ-015 busy  output  1  state is not RUN.
REQ-016 miss_count  output  8  saturating count of completed refills.

Function
REQ-017 FSM states SHALL be RUN (00), REFILL (01), RESUME (10); code 11 SHALL return to RUN on the next clock.
REQ-018 Define miss = mem_access AND NOT dcache_hit; enables, flushes and refill strobes SHALL be combinational from state and inputs.
REQ-019 RUN with miss: all five enables 0, no flushes, next state REFILL, word counter cleared to 0.
REQ-020 REFILL: refill_req=1, all enables 0; refill_word = counter; refill_we = mem_ready.
REQ-021 REFILL: counter SHALL advance by 1 only on cycles with mem_ready=1; mem_ready=0 cycles hold counter and state, with no timeout.
REQ-022 REFILL with mem_ready=1 and counter=3: state goes to RESUME, counter wraps to 0, miss_count increments (saturating at 255).
REQ-023 RESUME: all enables 0 for exactly one cycle, then RUN; refill_req=0.
REQ-024 Priority in RUN: miss > branch_taken > load-use hazard.
REQ-025 Branch flush (RUN, no miss, branch_taken=1): all enables 1, if_id_flush=id_ex_flush=ex_mem_flush=1; hazard ignored; no extra cycles.
REQ-026 Load-use hazard = id_ex_memread AND id_ex_rt!=0 AND (id_ex_rt==if_id_rs OR id_ex_rt==if_id_rt).
REQ-027 Hazard response (RUN, no miss, no branch): pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=ex_mem_hit=mem_wb_en=1; lasts one cycle.
REQ-028 RUN, no miss, no branch, no hazard: all enables 1, all flushes 0.
REQ-029 Branch or hazard conditions present during REFILL/RESUME SHALL be ignored, and evaluated only once RUN is re-entered.
REQ-030 busy = (state != RUN).

Reset
REQ-031 While rst=1, all enables SHALL be 0, all three flushes 1, and refill_req=refill_we=0.
REQ-032 A rising edge with rst=1 SHALL set state RUN, counter 0, miss_count 0, regardless of current state, including mid-REFILL (refill aborted, no miss_count increment).

Verification
REQ-033 Miss with mem_ready held 1: 1 RUN stall cycle, then 4 REFILL cycles with refill_word 0,1,2,3 and refill_we=1, then 1 RESUME cycle; enables return to 1 on cycle 7; miss_count=1.
REQ-034 Miss with mem_ready pulsing 1,0,1,0,1,0,1: REFILL lasts 7 cycles; refill_we asserted only on the four pulses, with words 0..3 in order.
REQ-035 id_ex_memread=1, id_ex_rt=3, if_id_rs=3: one cycle pc_en=0, if_id_en=0, id_ex_flush=1; with id_ex_rt=0, no stall.
REQ-036 branch_taken=1 together with a load-use hazard: three flushes=1, pc_en=1; branch_taken with miss: enables 0, no flush, state goes to REFILL.
REQ-037 rst=1 asserted during REFILL at word 2: next cycle state RUN, refill_req=0, miss_count unchanged; 256 completed refills leave miss_count=255.
